conv3x3_mac: RTL and testbench
==============================

CONV3X3_MAC -- requirements
Module: conv3x3_mac

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: unsigned pixel width.
REQ-002 SHALL have parameter KERNEL_SIZE, default 3: window side; only 3 is supported.
REQ-003 SHALL have parameter COEF_WIDTH, default 8: signed two's-complement coefficient width.
REQ-004 SHALL have parameter SHIFT, default 0: arithmetic right shift applied before pixel clamp.
REQ-005 SHALL have port clk  input  1: single clock; all logic on the rising edge.
REQ-006 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port window_flat  input  DATA_WIDTH*9: window; element k=r*3+c occupies bits [DATA_WIDTH*(k+1)-1 -: DATA_WIDTH].
REQ-008 SHALL have port valid_in  input  1: window_flat is valid this cycle.
REQ-009 SHALL have port coef_load  input  1: one-cycle pulse that starts a kernel load.
REQ-010 SHALL have port coef_we  input  1: coefficient write strobe.
REQ-011 SHALL have port coef_in  input  COEF_WIDTH: coefficient data, written in order k=0..8.
REQ-012 SHALL have port coef_ready  output  1: an active kernel exists.
REQ-013 SHALL have port acc_out  output  ACC_WIDTH: signed full-precision sum, with ACC_WIDTH=DATA_WIDTH+COEF_WIDTH+5.
REQ-014 SHALL have port pixel_out  output  DATA_WIDTH: (acc>>>SHIFT) clamped to [0, 2^DATA_WIDTH-1].
REQ-015 SHALL have port valid_out  output  1: acc_out and pixel_out are valid.

Function
REQ-016 SHALL run an FSM with states IDLE (no kernel), LOAD (collecting) and RUN (kernel active).
REQ-017 SHALL go from IDLE or RUN to LOAD on coef_load, clearing the 4-bit write counter to 0.
REQ-018 SHALL, in LOAD, write coef_in to shadow[cnt] on each coef_we and increment cnt; coef_we outside LOAD is ignored.
REQ-019 SHALL, on the 9th write (cnt=8), copy the shadow bank into the active bank on that same edge, go to RUN and set coef_ready.
REQ-020 SHALL, when coef_load occurs during LOAD, restart the counter at 0; partial shadow contents are discarded logically.
REQ-021 SHALL, when coef_load and coef_we coincide, take coef_load and ignore that write.
REQ-022 SHALL ignore valid_in while coef_ready=0; during LOAD entered from RUN, windows continue to be processed with the old active bank.
REQ-023 SHALL, for a window accepted on the edge where the 9th coefficient is written, use the old bank; from the next edge on, the new bank is used.
REQ-024 SHALL use a 3-stage pipeline: S1 registers 9 products of zero-extended pixel times signed coef; S2 registers 3 row sums; S3 registers the total, acc_out, pixel_out and valid_out.
REQ-025 SHALL assert valid_out exactly 3 cycles after an accepted valid_in, with throughput one window per cycle and no backpressure.
REQ-026 SHALL sign-extend all arithmetic to ACC_WIDTH and never overflow; a negative shifted value clamps pixel_out to 0, and a value above 2^DATA_WIDTH-1 clamps to 2^DATA_WIDTH-1.
REQ-027 SHALL hold acc_out and pixel_out when valid_out=0; valid_out SHALL be 0 for cycles with no accepted input.

Reset
REQ-028 SHALL, on rst, force: FSM=IDLE, cnt=0, both banks=0, all pipeline valids=0, coef_ready=0, acc_out=0, pixel_out=0, valid_out=0.
REQ-029 SHALL, on rst mid-pipeline, drop all in-flight windows: valid_out=0 on the cycle after rst is sampled, and no stale result appears afterwards.

Configuration
REQ-030 SHALL, with CONV_RELU_EN defined, drive acc_out to 0 whenever the S3 sum is negative; pixel_out is unchanged.
REQ-031 SHALL, without CONV_RELU_EN, drive acc_out as the raw signed sum.

Structure
REQ-032 SHALL place the FSM state encoding, ACC_WIDTH derivation and number of taps (9) in shared package conv_pkg.
REQ-033 SHALL implement coefficient storage (shadow, active, counter, FSM) in sub-module conv_coef_bank; the datapath stays in conv3x3_mac.

Verification
REQ-034 SHALL cover: all coefs 1, window all 10, SHIFT=0 -> acc_out=90, pixel_out=90, valid_out 3 cycles after valid_in.
REQ-035 SHALL cover: coef k=4 set to 1 and others 0, window k values 1..9 -> acc_out=5, pixel_out=5.
REQ-036 SHALL cover: all coefs -1, window all 255 -> acc_out=-2295 (0 with CONV_RELU_EN), pixel_out=0.
REQ-037 SHALL cover: all coefs 127, window all 255 -> acc_out=291465, pixel_out=255; with SHIFT=8 -> pixel_out=255, and with coefs 1 -> 2295>>>8=8.
REQ-038 SHALL cover: streaming valid_in every cycle while reloading from all-1 to all-2, window all 1 -> outputs 9 up to and including the window on the 9th-write edge, then 18, with no gaps.
REQ-039 SHALL cover: valid_in before any load -> no valid_out; rst asserted with 2 windows in flight -> valid_out=0 on the next cycle and stays 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution MAC: coefficient FSM states,
// tap count and accumulator width derivation.
package conv_pkg;

  localparam int NUM_TAPS = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } coef_state_e;

  // Nine products of (DATA_WIDTH+1)x(COEF_WIDTH) bits plus headroom for the sum.
  function automatic int acc_width(input int data_width, input int coef_width);
    return data_width + coef_width + 5;
  endfunction

endpackage

// File: rtl/conv_coef_bank.sv
// Double-buffered coefficient store: a shadow bank filled one word per write,
// committed to the active bank on the ninth write.
module conv_coef_bank
  import conv_pkg::*;
#(
  parameter int COEF_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 coef_load,
  input  logic                                 coef_we,
  input  logic [COEF_WIDTH-1:0]                coef_in,
  output logic                                 coef_ready,
  output logic [NUM_TAPS-1:0][COEF_WIDTH-1:0]  active
);

  coef_state_e                          state;
  logic [3:0]                           cnt;
  logic [NUM_TAPS-1:0][COEF_WIDTH-1:0]  shadow;
  logic [NUM_TAPS-1:0][COEF_WIDTH-1:0]  shadow_next;

  // NOTE: assign a default first so every path drives the signal and no latch is inferred.
  always_comb begin
    shadow_next      = shadow;
    shadow_next[cnt] = coef_in;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      coef_ready <= 1'b0;
      // NOTE: both banks are small register arrays and must read as zero after reset.
      shadow     <= '0;
      active     <= '0;
    end else if (coef_load) begin
      state <= ST_LOAD;
      cnt   <= '0;
    end else if (state == ST_LOAD && coef_we) begin
      shadow <= shadow_next;
      if (cnt == 4'(NUM_TAPS - 1)) begin
        // Commit includes the word written on this same edge.
        active     <= shadow_next;
        state      <= ST_RUN;
        coef_ready <= 1'b1;
        cnt        <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/conv3x3_mac.sv
// 3x3 convolution multiply-accumulate, 3-stage pipeline, one window per cycle.
// Define CONV_RELU_EN to zero acc_out for negative sums.
module conv3x3_mac
  import conv_pkg::*;
#(
  parameter int  DATA_WIDTH  = 8,
  parameter int  KERNEL_SIZE = 3,
  parameter int  COEF_WIDTH  = 8,
  parameter int  SHIFT       = 0,
  localparam int ACC_WIDTH   = acc_width(DATA_WIDTH, COEF_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH*9-1:0]      window_flat,
  input  logic                         valid_in,
  input  logic                         coef_load,
  input  logic                         coef_we,
  input  logic [COEF_WIDTH-1:0]        coef_in,
  output logic                         coef_ready,
  output logic signed [ACC_WIDTH-1:0]  acc_out,
  output logic [DATA_WIDTH-1:0]        pixel_out,
  output logic                         valid_out
);

  localparam logic signed [ACC_WIDTH-1:0] PIX_MAX =
    {{(ACC_WIDTH - DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

  logic [NUM_TAPS-1:0][COEF_WIDTH-1:0] coef_active;
  logic                                accept;
  logic signed [ACC_WIDTH-1:0]         prod_d [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0]         prod_q [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0]         row_d  [KERNEL_SIZE];
  logic signed [ACC_WIDTH-1:0]         row_q  [KERNEL_SIZE];
  logic signed [ACC_WIDTH-1:0]         total_d;
  logic signed [ACC_WIDTH-1:0]         shifted;
  logic signed [ACC_WIDTH-1:0]         acc_d;
  logic [DATA_WIDTH-1:0]               pix_d;
  logic                                v1, v2;

  conv_coef_bank #(.COEF_WIDTH(COEF_WIDTH)) u_coef_bank (
    .clk        (clk),
    .rst        (rst),
    .coef_load  (coef_load),
    .coef_we    (coef_we),
    .coef_in    (coef_in),
    .coef_ready (coef_ready),
    .active     (coef_active)
  );

  assign accept = valid_in & coef_ready;

  // Pixels are unsigned, so zero-extend them; coefficients sign-extend.
  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      prod_d[k] = $signed({{(ACC_WIDTH - DATA_WIDTH){1'b0}}, window_flat[DATA_WIDTH*k +: DATA_WIDTH]})
                * $signed({{(ACC_WIDTH - COEF_WIDTH){coef_active[k][COEF_WIDTH-1]}}, coef_active[k]});
    end
  end

  always_comb begin
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      row_d[r] = '0;
      for (int c = 0; c < KERNEL_SIZE; c++) begin
        row_d[r] = row_d[r] + prod_q[r*KERNEL_SIZE + c];
      end
    end
  end

  always_comb begin
    total_d = '0;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      total_d = total_d + row_q[r];
    end
    shifted = total_d >>> SHIFT;
    if (shifted[ACC_WIDTH-1])    pix_d = '0;
    else if (shifted > PIX_MAX)  pix_d = '1;
    else                         pix_d = shifted[DATA_WIDTH-1:0];
`ifdef CONV_RELU_EN
    acc_d = total_d[ACC_WIDTH-1] ? '0 : total_d;
`else
    acc_d = total_d;
`endif
  end

  // NOTE: product and row-sum registers carry no reset; the valid chain alone qualifies them.
  always_ff @(posedge clk) begin
    if (accept) prod_q <= prod_d;
    if (v1)     row_q  <= row_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      valid_out <= 1'b0;
      acc_out   <= '0;
      pixel_out <= '0;
    end else begin
      v1        <= accept;
      v2        <= v1;
      valid_out <= v2;
      if (v2) begin
        acc_out   <= acc_d;
        pixel_out <= pix_d;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_mac.sv
// Randomized and directed bench for conv3x3_mac against a queue-based kernel model.
module tb_conv3x3_mac;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int AW = DW + CW + 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW*9-1:0] window_flat = '0;
  logic          valid_in = 1'b0;
  logic          coef_load = 1'b0;
  logic          coef_we = 1'b0;
  logic [CW-1:0] coef_in = '0;
  logic          coef_ready, coef_ready8;
  logic [AW-1:0] acc_out, acc_out8;
  logic [DW-1:0] pixel_out, pixel_out8;
  logic          valid_out, valid_out8;

  always #5 clk = ~clk;

  conv3x3_mac #(.DATA_WIDTH(DW), .KERNEL_SIZE(3), .COEF_WIDTH(CW), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .window_flat(window_flat), .valid_in(valid_in),
    .coef_load(coef_load), .coef_we(coef_we), .coef_in(coef_in),
    .coef_ready(coef_ready), .acc_out(acc_out), .pixel_out(pixel_out), .valid_out(valid_out));

  conv3x3_mac #(.DATA_WIDTH(DW), .KERNEL_SIZE(3), .COEF_WIDTH(CW), .SHIFT(8)) dut8 (
    .clk(clk), .rst(rst), .window_flat(window_flat), .valid_in(valid_in),
    .coef_load(coef_load), .coef_we(coef_we), .coef_in(coef_in),
    .coef_ready(coef_ready8), .acc_out(acc_out8), .pixel_out(pixel_out8), .valid_out(valid_out8));

  typedef struct {
    longint acc;
    int     pix;
    int     pix8;
    int     due;
  } res_t;

  int     vectors = 0;
  int     miscompares = 0;
  int     cyc = 0;
  int     nvalid = 0;
  int     pix[9];
  int     kbuf[9];
  int     kern[9];
  bit     ready = 0;
  bit     loading = 0;
  int     shq[$];
  res_t   pend[$];
  longint last_acc = 0;
  int     last_pix = 0, last_pix8 = 0;
  longint cap_acc = 0;
  int     cap_pix = 0, cap_pix8 = 0, cap_cyc = 0, in_cyc = 0;
  bit     collecting = 0;
  longint seq[$];
  int     seq_cyc[$];

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int clamp_pix(input longint s, input int sh);
    longint v = s >>> sh;
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return int'(v);
  endfunction

  function automatic res_t predict();
    res_t   r;
    longint s = 0;
    for (int k = 0; k < 9; k++) s += longint'(pix[k]) * longint'(kern[k]);
`ifdef CONV_RELU_EN
    r.acc = (s < 0) ? 0 : s;
`else
    r.acc = s;
`endif
    r.pix  = clamp_pix(s, 0);
    r.pix8 = clamp_pix(s, 8);
    r.due  = 0;
    return r;
  endfunction

  // One clock: update the model with the inputs about to be sampled, then compare.
  task automatic step();
    bit   was_rst;
    bit   exp_v;
    res_t r;
    for (int k = 0; k < 9; k++) window_flat[DW*k +: DW] = 8'(pix[k]);
    was_rst = rst;
    if (rst) begin
      pend.delete();
      shq.delete();
      ready   = 0;
      loading = 0;
      for (int k = 0; k < 9; k++) kern[k] = 0;
    end else begin
      if (valid_in && ready) begin
        r     = predict();
        r.due = cyc + 3;
        pend.push_back(r);
      end
      if (coef_load) begin
        loading = 1;
        shq.delete();
      end else if (loading && coef_we) begin
        shq.push_back(int'($signed(coef_in)));
        if (shq.size() == 9) begin
          for (int k = 0; k < 9; k++) kern[k] = shq[k];
          ready   = 1;
          loading = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (was_rst) begin
      last_acc  = 0;
      last_pix  = 0;
      last_pix8 = 0;
    end
    exp_v = (pend.size() > 0) && (pend[0].due == cyc);
    check("valid_out", longint'(valid_out), longint'(exp_v));
    check("valid_out_sh8", longint'(valid_out8), longint'(exp_v));
    check("coef_ready", longint'(coef_ready), longint'(ready));
    check("coef_ready_sh8", longint'(coef_ready8), longint'(ready));
    if (exp_v) begin
      r         = pend.pop_front();
      last_acc  = r.acc;
      last_pix  = r.pix;
      last_pix8 = r.pix8;
    end
    check("acc_out", longint'($signed(acc_out)), last_acc);
    check("pixel_out", longint'(pixel_out), longint'(last_pix));
    check("pixel_out_sh8", longint'(pixel_out8), longint'(last_pix8));
    if (valid_out) begin
      nvalid++;
      cap_acc  = longint'($signed(acc_out));
      cap_pix  = int'(pixel_out);
      cap_pix8 = int'(pixel_out8);
      cap_cyc  = cyc;
      if (collecting) begin
        seq.push_back(cap_acc);
        seq_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic fill_pix(input int v);
    for (int k = 0; k < 9; k++) pix[k] = v;
  endtask

  task automatic fill_kbuf(input int v);
    for (int k = 0; k < 9; k++) kbuf[k] = v;
  endtask

  task automatic write_kernel();
    coef_we = 1'b1;
    for (int i = 0; i < 9; i++) begin
      coef_in = 8'(kbuf[i]);
      step();
    end
    coef_we = 1'b0;
  endtask

  task automatic load_kernel();
    coef_load = 1'b1;
    step();
    coef_load = 1'b0;
    write_kernel();
  endtask

  task automatic one_window();
    in_cyc   = cyc;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    int n_before;
    int gaps;

    fill_pix(0);
    fill_kbuf(0);
    for (int k = 0; k < 9; k++) kern[k] = 0;

    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    check("rst_acc_zero", longint'($signed(acc_out)), 0);
    check("rst_ready_zero", longint'(coef_ready), 0);

    // Windows before any kernel exists must be dropped.
    n_before = nvalid;
    fill_pix(5);
    valid_in = 1'b1;
    repeat (4) step();
    valid_in = 1'b0;
    repeat (4) step();
    check("noload_valid_count", nvalid - n_before, 0);

    fill_kbuf(1);
    load_kernel();
    fill_pix(10);
    one_window();
    check("ones_x10_acc", cap_acc, 90);
    check("ones_x10_pix", cap_pix, 90);
    check("ones_x10_latency", cap_cyc - in_cyc, 3);

    fill_kbuf(0);
    kbuf[4] = 1;
    load_kernel();
    for (int k = 0; k < 9; k++) pix[k] = k + 1;
    one_window();
    check("center_acc", cap_acc, 5);
    check("center_pix", cap_pix, 5);

    fill_kbuf(-1);
    load_kernel();
    fill_pix(255);
    one_window();
`ifdef CONV_RELU_EN
    check("neg_acc", cap_acc, 0);
`else
    check("neg_acc", cap_acc, -2295);
`endif
    check("neg_pix", cap_pix, 0);

    fill_kbuf(127);
    load_kernel();
    one_window();
    check("max_acc", cap_acc, 291465);
    check("max_pix", cap_pix, 255);
    check("max_pix_sh8", cap_pix8, 255);

    fill_kbuf(1);
    load_kernel();
    one_window();
    check("sum255_acc", cap_acc, 2295);
    check("sum255_pix_sh8", cap_pix8, 8);

    // Streaming reload from all-1 to all-2 with a window every cycle.
    seq.delete();
    seq_cyc.delete();
    fill_pix(1);
    collecting = 1;
    valid_in   = 1'b1;
    repeat (2) step();
    fill_kbuf(2);
    load_kernel();
    repeat (5) step();
    valid_in = 1'b0;
    repeat (4) step();
    collecting = 0;
    check("stream_len", seq.size(), 17);
    gaps = 0;
    for (int i = 0; i < seq.size(); i++) begin
      check("stream_val", seq[i], (i < 12) ? 9 : 18);
      if (i > 0 && seq_cyc[i] != seq_cyc[i-1] + 1) gaps++;
    end
    check("stream_gaps", gaps, 0);

    // Aborted load, then a coincident load+write whose write must be ignored.
    coef_load = 1'b1;
    step();
    coef_load = 1'b0;
    coef_we   = 1'b1;
    coef_in   = 8'd3;
    repeat (4) step();
    coef_load = 1'b1;
    coef_in   = 8'd99;
    step();
    coef_load = 1'b0;
    coef_we   = 1'b0;
    for (int k = 0; k < 9; k++) kbuf[k] = k + 1;
    write_kernel();
    fill_pix(2);
    one_window();
    check("restart_acc", cap_acc, 90);

    // Reset with two windows in flight.
    fill_pix(7);
    valid_in = 1'b1;
    repeat (2) step();
    valid_in = 1'b0;
    rst      = 1'b1;
    n_before = nvalid;
    step();
    rst = 1'b0;
    repeat (6) step();
    check("rst_flight_valid_count", nvalid - n_before, 0);
    check("rst_flight_ready", longint'(coef_ready), 0);

    // Random traffic including reloads, aborts and occasional resets.
    for (int k = 0; k < 9; k++) kbuf[k] = int'($signed(8'($urandom_range(0, 255))));
    load_kernel();
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      coef_load = ($urandom_range(0, 29) == 0);
      coef_we   = ($urandom_range(0, 1) == 1);
      coef_in   = 8'($urandom_range(0, 255));
      valid_in  = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 9; k++) pix[k] = (i % 50 < 10) ? 255 : int'($urandom_range(0, 255));
      step();
    end
    rst       = 1'b0;
    coef_load = 1'b0;
    coef_we   = 1'b0;
    valid_in  = 1'b0;
    repeat (5) step();
    check("final_pending_empty", pend.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
